// File: rtl/alu_exec_unit_pkg.sv
// Shared encodings for the Simple RISC Machine execute unit: instruction
// fields, opcode/op pairs, shift and ALU operation codes, FSM state codes.
package alu_exec_unit_pkg;

  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [2:0] ST_WAIT      = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_WRITE_IMM = 3'd2;
  localparam logic [2:0] ST_GET_A     = 3'd3;
  localparam logic [2:0] ST_GET_B     = 3'd4;
  localparam logic [2:0] ST_EXEC      = 3'd5;
  localparam logic [2:0] ST_WRITE_REG = 3'd6;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } instr_t;

  // imm8 spans the rd/sh/rm fields of a MOV-immediate.
  function automatic logic [15:0] sx_imm8(input instr_t ir);
    logic [7:0] imm;
    imm = {ir.rd, ir.sh, ir.rm};
    return {{8{imm[7]}}, imm};
  endfunction

endpackage

// File: rtl/ALU.sv
// Existing datapath ALU: add, subtract, and, not-B; Z flags a zero result.
module ALU (
  input  logic [15:0] Ain,
  input  logic [15:0] Bin,
  input  logic [1:0]  ALUop,
  output logic [15:0] out,
  output logic        Z
);

  always_comb begin
    case (ALUop)
      2'b00:   out = Ain + Bin;
      2'b01:   out = Ain - Bin;
      2'b10:   out = Ain & Bin;
      default: out = ~Bin;
    endcase
  end

  assign Z = (out == 16'h0000);

endmodule

// File: rtl/regfile8x16.sv
// Eight 16-bit registers: one synchronous write port, one combinational read port.
module regfile8x16 (
  input  logic        clk,
  input  logic        i_write,
  input  logic [2:0]  i_writenum,
  input  logic [2:0]  i_readnum,
  input  logic [15:0] i_data,
  output logic [15:0] o_data
);

  logic [15:0] r_mem [8];

  // NOTE: storage arrays carry no reset; software must write a register before reading it.
  always_ff @(posedge clk) begin
    if (i_write) r_mem[i_writenum] <= i_data;
  end

  assign o_data = r_mem[i_readnum];

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute unit: sequences regfile reads into A/B, runs the ALU,
// writes the result back to the regfile and to output register C.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] in,
  output logic        w,
  output logic [15:0] out,
  output logic        N,
  output logic        V,
  output logic        Z
);

  logic [2:0]  r_state;
  instr_t      r_ir;
  logic [15:0] r_a, r_b, r_c;
  logic        r_n, r_v, r_z;

  logic [2:0]  w_next_state;
  logic        w_is_mov, w_is_cmp;
  logic        w_write;
  logic [2:0]  w_readnum, w_writenum;
  logic [15:0] w_wdata, w_rdata;
  logic [15:0] w_ain, w_bin, w_alu_out;
  logic [1:0]  w_aluop;
  logic        w_alu_z;

  assign w_is_mov = (r_ir.opcode == OPC_MOV);
  assign w_is_cmp = (r_ir.opcode == OPC_ALU) && (r_ir.op == OP_CMP);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = ST_WAIT;
    case (r_state)
      ST_WAIT:   w_next_state = s ? ST_DECODE : ST_WAIT;
      ST_DECODE: begin
        if (w_is_mov && r_ir.op == OP_MOV_IMM)                 w_next_state = ST_WRITE_IMM;
        else if (w_is_mov && r_ir.op == OP_MOV_REG)            w_next_state = ST_GET_B;
        else if (r_ir.opcode == OPC_ALU && r_ir.op == OP_MVN)  w_next_state = ST_GET_B;
        else if (r_ir.opcode == OPC_ALU)                       w_next_state = ST_GET_A;
        else                                                   w_next_state = ST_WAIT;
      end
      ST_GET_A:  w_next_state = ST_GET_B;
      ST_GET_B:  w_next_state = ST_EXEC;
      ST_EXEC:   w_next_state = w_is_cmp ? ST_WAIT : ST_WRITE_REG;
      default:   w_next_state = ST_WAIT;
    endcase
  end

  always_comb begin
    w_bin = r_b;
    case (r_ir.sh)
      SH_LSL:  w_bin = {r_b[14:0], 1'b0};
      SH_LSR:  w_bin = {1'b0, r_b[15:1]};
      SH_ASR:  w_bin = {r_b[15], r_b[15:1]};
      default: w_bin = r_b;
    endcase
  end

  assign w_ain   = w_is_mov ? 16'h0000 : r_a;
  assign w_aluop = w_is_mov ? ALU_ADD : r_ir.op;

  ALU u_alu (
    .Ain   (w_ain),
    .Bin   (w_bin),
    .ALUop (w_aluop),
    .out   (w_alu_out),
    .Z     (w_alu_z)
  );

  // A write pending on the reset edge is dropped.
  assign w_write    = !reset && (r_state == ST_WRITE_IMM || r_state == ST_WRITE_REG);
  assign w_readnum  = (r_state == ST_GET_A) ? r_ir.rn : r_ir.rm;
  assign w_writenum = (r_state == ST_WRITE_IMM) ? r_ir.rn : r_ir.rd;
  assign w_wdata    = (r_state == ST_WRITE_IMM) ? sx_imm8(r_ir) : r_c;

  regfile8x16 u_regfile (
    .clk        (clk),
    .i_write    (w_write),
    .i_writenum (w_writenum),
    .i_readnum  (w_readnum),
    .i_data     (w_wdata),
    .o_data     (w_rdata)
  );

  // NOTE: state registers use non-blocking assignment so all of them update together on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_WAIT;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_WAIT:  if (s) r_ir <= in;
        ST_GET_A: r_a <= w_rdata;
        ST_GET_B: r_b <= w_rdata;
        ST_EXEC: begin
          if (w_is_cmp) begin
            r_z <= w_alu_z;
            r_n <= w_alu_out[15];
            r_v <= (w_ain[15] != w_bin[15]) && (w_alu_out[15] != w_ain[15]);
          end else begin
            r_c <= w_alu_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign w   = (r_state == ST_WAIT);
  assign out = r_c;
  assign N   = r_n;
  assign V   = r_v;
  assign Z   = r_z;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed program plus randomized
// instruction stream checked against an architectural register/flag model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [15:0] in;
  logic        w;
  logic [15:0] out;
  logic        N, V, Z;

  alu_exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .in    (in),
    .w     (w),
    .out   (out),
    .N     (N),
    .V     (V),
    .Z     (Z)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit noise    = 1'b0;

  logic [15:0] m_reg [8];
  logic [15:0] m_c;
  logic        m_n, m_v, m_z;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] shift_val(input logic [15:0] b, input logic [1:0] sh);
    case (sh)
      2'd1:    return b << 1;
      2'd2:    return b >> 1;
      2'd3:    return 16'($signed(b) >>> 1);
      default: return b;
    endcase
  endfunction

  // Architectural effect of one instruction; returns edges from accept to ready.
  task automatic model_step(input logic [15:0] ins, output int lat);
    logic [2:0]  opc, rn, rd, rm;
    logic [1:0]  op, sh;
    logic [15:0] a, b, r;
    opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8];
    rd  = ins[7:5];   sh = ins[4:3];   rm = ins[2:0];
    b = shift_val(m_reg[rm], sh);
    a = m_reg[rn];
    lat = 2;
    if (opc == 3'b110 && op == 2'b10) begin
      m_reg[rn] = {{8{ins[7]}}, ins[7:0]};
      lat = 3;
    end else if (opc == 3'b110 && op == 2'b00) begin
      m_reg[rd] = b; m_c = b; lat = 5;
    end else if (opc == 3'b101) begin
      case (op)
        2'b00: begin r = a + b; m_reg[rd] = r; m_c = r; lat = 6; end
        2'b01: begin
          r = a - b;
          m_z = (r == 16'd0);
          m_n = r[15];
          m_v = (a[15] != b[15]) && (r[15] != a[15]);
          lat = 5;
        end
        2'b10: begin r = a & b; m_reg[rd] = r; m_c = r; lat = 6; end
        default: begin r = ~b; m_reg[rd] = r; m_c = r; lat = 5; end
      endcase
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out"}, 32'(out), 32'(m_c));
    check({tag, ".nvz"}, 32'({N, V, Z}), 32'({m_n, m_v, m_z}));
  endtask

  task automatic run_instr(input logic [15:0] ins, input string tag);
    int exp_lat, edges;
    model_step(ins, exp_lat);
    s = 1'b1; in = ins;
    tick();
    s = 1'b0;
    check({tag, ".w_fall"}, 32'(w), 32'd0);
    edges = 1;
    while (!w && edges < 20) begin
      if (noise) begin s = 1'($urandom_range(0, 1)); in = 16'($urandom); end
      tick();
      edges++;
    end
    s = 1'b0;
    check({tag, ".latency"}, 32'(edges), 32'(exp_lat));
    check_outputs(tag);
  endtask

  // Start an instruction, then assert reset on the edge after k edges have elapsed.
  task automatic reset_after(input logic [15:0] ins, input int k, input string tag);
    s = 1'b1; in = ins;
    tick();
    s = 1'b0;
    repeat (k - 1) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_c = 16'd0; m_n = 1'b0; m_v = 1'b0; m_z = 1'b0;
    check({tag, ".w"}, 32'(w), 32'd1);
    check_outputs(tag);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] ins;
    int k;
    k = $urandom_range(0, 9);
    ins = 16'($urandom);
    if (k <= 1)      ins[15:11] = 5'b110_10;
    else if (k == 2) ins[15:11] = 5'b110_00;
    else if (k <= 8) ins[15:13] = 3'b101;
    else if (ins[15:13] == 3'b101 || (ins[15:13] == 3'b110 && ins[11] == 1'b0))
      ins[15:13] = 3'b111;
    return ins;
  endfunction

  initial begin
    s = 1'b0; in = 16'h0000; reset = 1'b1;
    m_c = 16'd0; m_n = 1'b0; m_v = 1'b0; m_z = 1'b0;
    for (int i = 0; i < 8; i++) m_reg[i] = 16'd0;
    tick();
    reset = 1'b0;
    check("reset.w", 32'(w), 32'd1);
    check("reset.out", 32'(out), 32'h0000);
    check("reset.nvz", 32'({N, V, Z}), 32'd0);
    repeat (5) tick();
    check("idle.w", 32'(w), 32'd1);
    check_outputs("idle");

    run_instr(16'hD003, "mov_r0");
    run_instr(16'hD10B, "mov_r1");
    run_instr(16'hA041, "add_r2");
    check("add_r2.lit", 32'(out), 32'h000E);
    run_instr(16'hA800, "cmp_r0r0");
    check("cmp_r0r0.lit", 32'({N, V, Z}), 32'b001);
    run_instr(16'hA801, "cmp_r0r1");
    check("cmp_r0r1.lit", 32'({N, V, Z}), 32'b100);
    run_instr(16'hB868, "mvn_r3");
    check("mvn_r3.lit", 32'(out), 32'hFFF9);
    run_instr(16'hE000, "undef");

    reset_after(16'hA041, 3, "rst_getb");
    run_instr(16'hA262, "add_r3");
    check("add_r3.lit", 32'(out), 32'h001C);

    run_instr(16'hD455, "mov_r4");
    reset_after(16'hA081, 5, "rst_wr");
    run_instr(16'hC0A4, "mov_r5_r4");
    check("mov_r5_r4.lit", 32'(out), 32'h0055);

    noise = 1'b1;
    for (int r = 0; r < 8; r++)
      run_instr({5'b110_10, 3'(r), 8'($urandom)}, "rand_init");
    for (int i = 0; i < 200; i++)
      run_instr(rand_instr(), "rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
